// File: rtl/cpu_icache.sv
// Direct-mapped one-word-per-line instruction cache with two combinational lookup slots.
// Misses refill the line byte-by-byte from a shared byte-wide RAM through a req/grant arbiter.
module cpu_icache #(
  parameter int INDEX_BITS = 7,
  parameter int ADDR_W     = 18
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        en_rx,
  input  logic        en_ry,
  input  logic [31:0] pcx,
  input  logic [31:0] pcy,
  output logic        hitx,
  output logic        hity,
  output logic [31:0] instx,
  output logic [31:0] insty,
  output logic        mem_req,
  input  logic        mem_grant,
  output logic [31:0] mem_a,
  input  logic [7:0]  mem_din
);
  localparam int TAG_W = ADDR_W - INDEX_BITS - 2;
  localparam int LINES = 1 << INDEX_BITS;
  localparam int PAD   = 32 - ADDR_W;

  typedef enum logic [1:0] {IDLE, WAIT, READ} state_t;

  state_t                  state;
  logic [2:0]              cnt;
  logic [ADDR_W-3:0]       maddr;
  logic [23:0]             lbuf;
  logic [LINES-1:0]        valid;
  logic [31:0]             data_arr [LINES];
  logic [TAG_W-1:0]        tag_arr  [LINES];

  logic [INDEX_BITS-1:0]   idx_x, idx_y, widx;
  logic [TAG_W-1:0]        tag_x, tag_y;
  logic                    miss_x, miss_y, fill;
  logic [1:0]              nxt_byte;
  logic                    unused_pc;

  assign idx_x = pcx[INDEX_BITS+1:2];
  assign idx_y = pcy[INDEX_BITS+1:2];
  assign tag_x = pcx[ADDR_W-1:INDEX_BITS+2];
  assign tag_y = pcy[ADDR_W-1:INDEX_BITS+2];

  assign hitx  = en_rx & valid[idx_x] & (tag_arr[idx_x] == tag_x);
  assign hity  = en_ry & valid[idx_y] & (tag_arr[idx_y] == tag_y);
  assign instx = data_arr[idx_x];
  assign insty = data_arr[idx_y];

  // Y is only worth refilling when X hits; otherwise fetch discards Y anyway.
  assign miss_x = en_rx & ~hitx;
  assign miss_y = en_ry & ~hity & hitx;

  assign widx     = maddr[INDEX_BITS-1:0];
  assign nxt_byte = cnt[1:0] + 2'd1;
  assign fill     = rdy & (state == READ) & (cnt == 3'd4);

  assign unused_pc = ^{pcx[31:ADDR_W], pcx[1:0], pcy[31:ADDR_W], pcy[1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= 3'd0;
      maddr   <= '0;
      mem_req <= 1'b0;
      mem_a   <= 32'd0;
      valid   <= '0;
    end else if (rdy) begin
      case (state)
        IDLE: begin
          if (miss_x) begin
            maddr   <= pcx[ADDR_W-1:2];
            mem_req <= 1'b1;
            state   <= WAIT;
          end else if (miss_y) begin
            maddr   <= pcy[ADDR_W-1:2];
            mem_req <= 1'b1;
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (mem_grant) begin
            mem_a <= {{PAD{1'b0}}, maddr, 2'b00};
            cnt   <= 3'd0;
            state <= READ;
          end
        end
        READ: begin
          cnt <= cnt + 3'd1;
          if (cnt < 3'd3) mem_a <= {{PAD{1'b0}}, maddr, nxt_byte};
          // RAM data lags the address by one cycle, so byte k lands when cnt == k+1.
          case (cnt)
            3'd1: lbuf[7:0]   <= mem_din;
            3'd2: lbuf[15:8]  <= mem_din;
            3'd3: lbuf[23:16] <= mem_din;
            3'd4: begin
              valid[widx] <= 1'b1;
              mem_req     <= 1'b0;
              state       <= IDLE;
            end
            default: ;
          endcase
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && fill) begin
      data_arr[widx] <= {mem_din, lbuf};
      tag_arr[widx]  <= maddr[ADDR_W-3:INDEX_BITS];
    end
  end

endmodule

// File: tb/tb_cpu_icache.sv
// Bench for cpu_icache: byte RAM and arbiter models plus an address-level cache reference model.
module tb_cpu_icache;
  logic        clk = 1'b0;
  logic        rst, rdy, en_rx, en_ry;
  logic [31:0] pcx, pcy, instx, insty, mem_a;
  logic        hitx, hity, mem_req, mem_grant;
  logic [7:0]  mem_din;

  int n_checks = 0;
  int n_fail   = 0;
  int grant_delay = 0;
  int wait_cnt = 0;

  logic [7:0] ram [4096];
  int line_addr [128];  // byte address cached at each index, -1 when empty

  always #5 clk = ~clk;

  cpu_icache #(.INDEX_BITS(7), .ADDR_W(18)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .en_rx(en_rx), .en_ry(en_ry),
    .pcx(pcx), .pcy(pcy), .hitx(hitx), .hity(hity), .instx(instx), .insty(insty),
    .mem_req(mem_req), .mem_grant(mem_grant), .mem_a(mem_a), .mem_din(mem_din)
  );

  assign mem_grant = mem_req && (wait_cnt >= grant_delay);

  always @(posedge clk) begin
    if (rst) wait_cnt <= 0;
    else if (rdy) begin
      if (!mem_req) wait_cnt <= 0;
      else if (!mem_grant) wait_cnt <= wait_cnt + 1;
    end
    if (rdy) mem_din <= ram[mem_a[11:0]];
  end

  function automatic logic [31:0] word_at(input int a);
    return {ram[a+3], ram[a+2], ram[a+1], ram[a]};
  endfunction

  function automatic bit model_hit(input int a);
    return line_addr[(a >> 2) % 128] == a;
  endfunction

  function automatic int rand_addr();
    return (int'($urandom_range(0, 3)) << 9) | (int'($urandom_range(0, 7)) << 2);
  endfunction

  task automatic do_reset();
    rst = 1'b1; rdy = 1'b1; en_rx = 1'b0; en_ry = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 128; i++) line_addr[i] = -1;
  endtask

  task automatic wait_hit(input bit on_y, output int n);
    bit seen;
    seen = 1'b0;
    n = 0;
    while (!seen && n < 100) begin
      @(posedge clk); n++;
      @(negedge clk);
      seen = on_y ? hity : hitx;
    end
    if (!seen) n = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1; rdy = 1'b1;
    en_rx = 1'b1; pcx = 32'h100; en_ry = 1'b1; pcy = 32'h104;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++; if (hitx !== 1'b0) begin n_fail++; $display("FAIL reset_hitx: got %b want 0", hitx); end
    n_checks++; if (hity !== 1'b0) begin n_fail++; $display("FAIL reset_hity: got %b want 0", hity); end
    n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", mem_req); end
    n_checks++; if (mem_a !== 32'h0) begin n_fail++; $display("FAIL reset_mem_a: got %h want 0", mem_a); end
    en_rx = 1'b0; en_ry = 1'b0;
  endtask

  task automatic test_cold_miss();
    do_reset();
    grant_delay = 0;
    ram[0] = 8'h13; ram[1] = 8'h00; ram[2] = 8'h00; ram[3] = 8'h00;
    en_rx = 1'b1; pcx = 32'h0;
    for (int j = 0; j <= 6; j++) begin
      @(posedge clk);
      @(negedge clk);
      if (j == 0) begin
        n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL cold_req: got %b want 1", mem_req); end
      end
      if (j >= 1 && j <= 4) begin
        n_checks++;
        if (mem_a !== 32'(j - 1)) begin n_fail++; $display("FAIL cold_mem_a[%0d]: got %h want %h", j, mem_a, j - 1); end
      end
      if (j == 5) begin
        n_checks++; if (hitx !== 1'b0) begin n_fail++; $display("FAIL cold_early_hit: got %b want 0", hitx); end
      end
    end
    n_checks++; if (hitx !== 1'b1) begin n_fail++; $display("FAIL cold_hit: got %b want 1", hitx); end
    n_checks++; if (instx !== 32'h13) begin n_fail++; $display("FAIL cold_inst: got %h want 00000013", instx); end
    line_addr[0] = 0;
    en_rx = 1'b0;
  endtask

  task automatic test_dual_hit();
    int n;
    bit req_seen;
    en_rx = 1'b1; pcx = 32'h4;
    wait_hit(1'b0, n);
    n_checks++; if (n != 7) begin n_fail++; $display("FAIL dual_fill_lat: got %0d want 7", n); end
    pcx = 32'h0; pcy = 32'h4; en_ry = 1'b1;
    #1;
    n_checks++; if ({hitx, hity} !== 2'b11) begin n_fail++; $display("FAIL dual_hits: got %b want 11", {hitx, hity}); end
    n_checks++; if (instx !== word_at(0)) begin n_fail++; $display("FAIL dual_instx: got %h want %h", instx, word_at(0)); end
    n_checks++; if (insty !== word_at(4)) begin n_fail++; $display("FAIL dual_insty: got %h want %h", insty, word_at(4)); end
    req_seen = 1'b0;
    repeat (3) begin @(posedge clk); @(negedge clk); if (mem_req) req_seen = 1'b1; end
    n_checks++; if (req_seen) begin n_fail++; $display("FAIL dual_no_req: got 1 want 0"); end
    en_rx = 1'b0; en_ry = 1'b0;
  endtask

  task automatic test_priority();
    int n;
    en_rx = 1'b1; pcx = 32'h10; en_ry = 1'b1; pcy = 32'h14;
    wait_hit(1'b0, n);
    n_checks++; if (n != 7) begin n_fail++; $display("FAIL prio_x_lat: got %0d want 7", n); end
    n_checks++; if (hity !== 1'b0) begin n_fail++; $display("FAIL prio_y_early: got %b want 0", hity); end
    n_checks++; if (mem_a !== 32'h13) begin n_fail++; $display("FAIL prio_x_addr: got %h want 13", mem_a); end
    wait_hit(1'b1, n);
    n_checks++; if (n != 7) begin n_fail++; $display("FAIL prio_y_lat: got %0d want 7", n); end
    n_checks++; if (mem_a !== 32'h17) begin n_fail++; $display("FAIL prio_y_addr: got %h want 17", mem_a); end
    n_checks++; if (insty !== word_at(32'h14)) begin n_fail++; $display("FAIL prio_insty: got %h want %h", insty, word_at(32'h14)); end
    n_checks++; if (instx !== word_at(32'h10)) begin n_fail++; $display("FAIL prio_instx: got %h want %h", instx, word_at(32'h10)); end
    en_rx = 1'b0; en_ry = 1'b0;
  endtask

  task automatic test_conflict();
    int n;
    en_rx = 1'b1; pcx = 32'h200;
    wait_hit(1'b0, n);
    n_checks++; if (n != 7) begin n_fail++; $display("FAIL conf_lat: got %0d want 7", n); end
    n_checks++; if (instx !== word_at(32'h200)) begin n_fail++; $display("FAIL conf_inst: got %h want %h", instx, word_at(32'h200)); end
    en_rx = 1'b0; pcx = 32'h0; en_ry = 1'b1; pcy = 32'h4;
    #1;
    n_checks++; if (hitx !== 1'b0) begin n_fail++; $display("FAIL conf_evicted: got %b want 0", hitx); end
    en_rx = 1'b1;
    #1;
    n_checks++; if (hitx !== 1'b0) begin n_fail++; $display("FAIL conf_old_line: got %b want 0", hitx); end
    n_checks++; if (hity !== 1'b1) begin n_fail++; $display("FAIL conf_neighbour: got %b want 1", hity); end
    en_rx = 1'b0; en_ry = 1'b0;
  endtask

  task automatic test_stall();
    int n;
    logic [31:0] held;
    bit moved;
    grant_delay = 3;
    en_rx = 1'b1; pcx = 32'h300;
    repeat (6) begin @(posedge clk); @(negedge clk); end
    n_checks++; if (mem_a !== 32'h301) begin n_fail++; $display("FAIL stall_pre_addr: got %h want 301", mem_a); end
    held = mem_a;
    moved = 1'b0;
    rdy = 1'b0;
    repeat (2) begin @(posedge clk); @(negedge clk); if (mem_a !== held || mem_req !== 1'b1) moved = 1'b1; end
    n_checks++; if (moved) begin n_fail++; $display("FAIL stall_frozen: got mem_a=%h req=%b want %h/1", mem_a, mem_req, held); end
    rdy = 1'b1;
    wait_hit(1'b0, n);
    if (n >= 0) n = n + 8;
    n_checks++; if (n != 12) begin n_fail++; $display("FAIL stall_lat: got %0d want 12", n); end
    n_checks++; if (instx !== word_at(32'h300)) begin n_fail++; $display("FAIL stall_inst: got %h want %h", instx, word_at(32'h300)); end
    grant_delay = 0;
    en_rx = 1'b0;
  endtask

  task automatic test_reset_mid();
    int n;
    grant_delay = 0;
    en_rx = 1'b1; pcx = 32'h40;
    repeat (5) begin @(posedge clk); @(negedge clk); end
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL rstmid_req: got %b want 0", mem_req); end
    n_checks++; if (hitx !== 1'b0) begin n_fail++; $display("FAIL rstmid_hit: got %b want 0", hitx); end
    en_ry = 1'b1; pcy = 32'h200;
    #1;
    n_checks++; if (hity !== 1'b0) begin n_fail++; $display("FAIL rstmid_cleared: got %b want 0", hity); end
    en_ry = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 128; i++) line_addr[i] = -1;
    repeat (2) begin @(posedge clk); @(negedge clk); end
    n_checks++; if (mem_a !== 32'h40) begin n_fail++; $display("FAIL rstmid_refetch: got %h want 40", mem_a); end
    wait_hit(1'b0, n);
    n_checks++; if (n != 5) begin n_fail++; $display("FAIL rstmid_lat: got %0d want 5", n); end
    n_checks++; if (instx !== word_at(32'h40)) begin n_fail++; $display("FAIL rstmid_inst: got %h want %h", instx, word_at(32'h40)); end
    line_addr[16] = 32'h40;
    en_rx = 1'b0;
  endtask

  task automatic test_same_pc();
    int n;
    en_rx = 1'b1; en_ry = 1'b1; pcx = 32'h80; pcy = 32'h80;
    wait_hit(1'b0, n);
    n_checks++; if (n != 7) begin n_fail++; $display("FAIL same_lat: got %0d want 7", n); end
    n_checks++; if (hity !== 1'b1) begin n_fail++; $display("FAIL same_hity: got %b want 1", hity); end
    @(posedge clk); @(negedge clk);
    n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL same_single: got %b want 0", mem_req); end
    en_rx = 1'b0; en_ry = 1'b0;
  endtask

  task automatic test_random();
    int a, b, n, target;
    bit ex, ey, expx, expy, on_y;
    do_reset();
    for (int it = 0; it < 60; it++) begin
      a = rand_addr(); b = rand_addr();
      ex = ($urandom_range(0, 3) != 0); ey = $urandom_range(0, 1) != 0;
      grant_delay = $urandom_range(0, 3);
      en_rx = ex; en_ry = ey; pcx = a; pcy = b;
      #1;
      expx = ex && model_hit(a);
      expy = ey && model_hit(b);
      n_checks++; if (hitx !== expx) begin n_fail++; $display("FAIL rnd_hitx it%0d: got %b want %b", it, hitx, expx); end
      n_checks++; if (hity !== expy) begin n_fail++; $display("FAIL rnd_hity it%0d: got %b want %b", it, hity, expy); end
      if (expx) begin
        n_checks++; if (instx !== word_at(a)) begin n_fail++; $display("FAIL rnd_instx it%0d: got %h want %h", it, instx, word_at(a)); end
      end
      if (expy) begin
        n_checks++; if (insty !== word_at(b)) begin n_fail++; $display("FAIL rnd_insty it%0d: got %h want %h", it, insty, word_at(b)); end
      end
      target = -1; on_y = 1'b0;
      if (ex && !expx) target = a;
      else if (ey && !expy && expx) begin target = b; on_y = 1'b1; end
      if (target >= 0) begin
        wait_hit(on_y, n);
        n_checks++; if (n != 7 + grant_delay) begin n_fail++; $display("FAIL rnd_lat it%0d: got %0d want %0d", it, n, 7 + grant_delay); end
        line_addr[(target >> 2) % 128] = target;
        n_checks++;
        if ((on_y ? insty : instx) !== word_at(target)) begin
          n_fail++; $display("FAIL rnd_fill it%0d: got %h want %h", it, on_y ? insty : instx, word_at(target));
        end
      end else begin
        @(posedge clk); @(negedge clk);
        n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL rnd_idle it%0d: got %b want 0", it, mem_req); end
      end
    end
    en_rx = 1'b0; en_ry = 1'b0;
    grant_delay = 0;
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; en_rx = 1'b0; en_ry = 1'b0;
    pcx = 32'h0; pcy = 32'h0;
    for (int i = 0; i < 4096; i++) ram[i] = 8'($urandom);
    for (int i = 0; i < 128; i++) line_addr[i] = -1;
    test_reset();
    test_cold_miss();
    test_dual_hit();
    test_priority();
    test_conflict();
    test_stall();
    test_reset_mid();
    test_same_pc();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_icache.md
# cpu_icache

Direct-mapped, one-word-per-line instruction cache that sits directly upstream of the dual-issue fetch stage. Answers two combinational lookups per cycle (slot X at `pcx`, slot Y at `pcy`) with hit flags and instruction words. On a miss, refills the missing line byte-by-byte from the shared byte-wide RAM through a request/grant arbiter. Hits stay available while a refill is in progress.

## Interface
Parameters:
- `INDEX_BITS`, 7: line index width; 2^INDEX_BITS lines of 32 bits.
- `ADDR_W`, 18: significant byte-address width; tag = `ADDR_W-INDEX_BITS-2` bits.

Ports:
- `clk`  in  1  single clock, all state on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `rdy`  in  1  global ready; low freezes all state.
- `en_rx`  in  1  slot X lookup enable.
- `en_ry`  in  1  slot Y lookup enable.
- `pcx`  in  32  slot X byte address (word aligned).
- `pcy`  in  32  slot Y byte address (word aligned).
- `hitx`  out  1  slot X hit, combinational.
- `hity`  out  1  slot Y hit, combinational.
- `instx`  out  32  slot X instruction; valid when `hitx`.
- `insty`  out  32  slot Y instruction; valid when `hity`.
- `mem_req`  out  1  refill bus request, registered.
- `mem_grant`  in  1  arbiter grant; held high while `mem_req` is high once given.
- `mem_a`  out  32  RAM byte address, registered; upper bits beyond `ADDR_W` are 0.
- `mem_din`  in  8  RAM read data, one cycle after `mem_a`.

## Operation
- Lookup: index = `pc[INDEX_BITS+1:2]`, tag = `pc[ADDR_W-1:INDEX_BITS+2]`. `hitx = en_rx & valid[idx] & tag match`; same for Y. `instx`/`insty` return the line word whatever the hit state.
- Miss select in IDLE, evaluated at each edge with `rdy=1`:
  - X miss (`en_rx & !hitx`): refill `pcx`.
  - Otherwise Y miss (`en_ry & !hity`) with `hitx=1`: refill `pcy`.
  - X always has priority. A Y miss while X also misses is ignored, because fetch will not consume Y.
- FSM states:
  - IDLE → WAIT: on a miss. Latch `maddr` (word aligned, `ADDR_W` bits). Set `mem_req <= 1`.
  - WAIT → READ: at the edge where `mem_grant=1`. Set `mem_a <= maddr`, `cnt <= 0`.
  - READ: each edge issues `mem_a <= maddr + cnt + 1` while cnt<3. Captures `mem_din` of the previous address into byte `cnt-1`, little-endian (byte 0 → bits 7:0).
  - READ → IDLE: at the edge capturing byte 3. Write the data word and tag. Set `valid <= 1` and `mem_req <= 0`.
- Partial line data is never visible. Hits on the line being refilled report 0 until the write edge.
- Replacement overwrites unconditionally, including a valid line with a different tag.
- Line address wrap: `maddr+k` never crosses a word, so there is no carry into the tag.

## Timing
- Reset values:
  - All `valid` = 0.
  - FSM = IDLE.
  - `mem_req` = 0.
  - `mem_a` = 0.
  - `hitx` = `hity` = 0, since valid is cleared.
- Hit latency: 0 cycles (combinational from `pcx`/`pcy`). Fetch registers the result.
- Refill with immediate grant: miss edge E0 (→WAIT), grant edge E1 (`mem_a`=byte 0), bytes captured at E3..E6, line valid after E6. The first hit is reported in the cycle after E6, 6 edges after the miss edge. Each grant-wait cycle adds one edge.
- `rdy=0`: FSM, counter, `mem_a`, `mem_req` and the arrays hold. Lookups remain combinational. The RAM/arbiter is frozen by the same `rdy`.
- `rst` mid-refill: abort. Return to IDLE, drop `mem_req` next cycle, clear all valids, write no partial line.
- The miss address is latched only in IDLE. Changing `pcx` during a refill does not redirect it. A new miss is taken on the first IDLE edge after completion.
- `pcx == pcy`, both missing: a single refill, and both hit afterwards.

## Test plan
- Cold miss: reset, `en_rx=1`, `pcx=0x0`, grant held high, RAM bytes 0..3 = 13,00,00,00. Required: `mem_req` rises after E0; `mem_a` = 0,1,2,3 on consecutive cycles; `hitx=1` with `instx=0x00000013` 6 edges after the miss edge.
- Dual hit: preload 0x0 and 0x4, `pcx=0x0`, `pcy=0x4`. Required: `hitx=hity=1` the same cycle, correct words, `mem_req` stays 0.
- Priority: X misses at 0x10 and Y misses at 0x14. Required: only 0x10 is fetched (`mem_a` 0x10..0x13). After that line fills, the Y miss triggers refill of 0x14.
- Conflict eviction (`INDEX_BITS=7`): fill 0x0, then miss 0x200. Required: 0x200 hits and 0x0 misses afterwards.
- Grant delay and `rdy` stall: hold `mem_grant=0` for 3 cycles, then drop `rdy` for 2 cycles mid-READ. Required: `mem_a` and `cnt` frozen during both; correct word assembled; total latency 6+3+2 edges.
- Reset mid-refill: assert `rst` after byte 1 is captured. Required: next cycle `mem_req=0`; `hitx=0` for that address; a fresh miss refetches from byte 0.
